conv_mac: RTL and testbench

- Multiply-accumulate stage directly downstream of the padding/overlay controller in the convolution datapath.
- Consumes one (pixel, coefficient) tap per accepted cycle; a pad tap contributes zero.
- Accumulates all taps of one kernel window, then rounds, shifts and saturates the sum to one output pixel channel.
- Replaces the separate multiplier/accumulator pair with one pipelined, back-pressured unit.

---
 rtl/conv_mac.sv | 165 ++++++++++++++++
 tb/tb_conv_mac.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - pipelined, back-pressured multiply-accumulate for convolution windows
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 9,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 4
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic [2:0]               kernel_size,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_pixel,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_pad,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     tap_err,
  output logic [15:0]              win_count
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  // Half an output LSB; zero when no shift is applied.
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

  // Tap counter / window bookkeeping
  logic [5:0]               r_tap_cnt;
  logic [2:0]               r_k;
  logic                     r_tap_err;

  // Stage 1: registered product and window flags
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_first;
  logic                     r_last;
  logic                     r_v1;

  // Stage 2: accumulator and output register
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_data;
  logic [15:0]              r_win_count;

  logic                     w_en;
  logic                     w_accept;
  logic [2:0]               w_k;
  logic [5:0]               w_kk;
  logic [5:0]               w_cnt_next;
  logic                     w_full;
  logic                     w_close;
  logic signed [PROD_W-1:0] w_pix_ext;
  logic signed [PROD_W-1:0] w_coef_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shr;
  logic [DATA_W-1:0]        w_sat;
  logic                     w_load;

  // The whole pipeline freezes only while a result is waiting and downstream refuses it.
  assign w_en     = !(r_out_valid && !out_ready);
  assign w_accept = in_valid && w_en;

  // Kernel size is taken live at the start of a window and held for the rest of it;
  // even sizes round up to the next odd size.
  assign w_k        = (r_tap_cnt == 6'd0) ? (kernel_size | 3'd1) : r_k;
  assign w_kk       = 6'(w_k) * 6'(w_k);
  assign w_cnt_next = r_tap_cnt + 6'd1;
  assign w_full     = (w_cnt_next == w_kk);
  assign w_close    = in_last || w_full;

  // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
  assign w_pix_ext  = PROD_W'($signed({1'b0, in_pixel}));
  assign w_coef_ext = PROD_W'(in_coef);
  assign w_prod     = in_pad ? '0 : (w_pix_ext * w_coef_ext);

  // The first tap of a window restarts the sum instead of adding to stale state.
  assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
  assign w_base     = r_first ? '0 : r_acc;
  assign w_sum      = w_base + w_prod_ext;
  assign w_rnd      = w_sum + RND;
  assign w_shr      = w_rnd >>> SHIFT;
  assign w_load     = w_en && r_v1 && r_last;

  // Clamp the rounded, shifted sum into the unsigned output range.
  always_comb begin
    w_sat = '0;
    if (w_shr < 0) begin
      w_sat = '0;
    end else if (w_shr > SAT_MAX) begin
      w_sat = '1;
    end else begin
      w_sat = w_shr[DATA_W-1:0];
    end
  end

  // Count taps, latch kernel size at window start, flag malformed window lengths.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_tap_cnt <= '0;
      r_k       <= 3'd1;
      r_tap_err <= 1'b0;
    end else if (w_accept) begin
      if (r_tap_cnt == 6'd0) begin
        r_k <= kernel_size | 3'd1;
      end
      r_tap_cnt <= w_close ? 6'd0 : w_cnt_next;
      if ((in_last && !w_full) || (!in_last && w_full)) begin
        r_tap_err <= 1'b1;
      end
    end
  end

  // Stage 1: register the product with its first/last window markers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_prod  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_en) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_prod  <= w_prod;
        r_first <= (r_tap_cnt == 6'd0);
        r_last  <= w_close;
      end
    end
  end

  // Stage 2: accumulate every valid product.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_en && r_v1) begin
      r_acc <= w_sum;
    end
  end

  // Output register: load on window close, drop valid once the result is taken.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_win_count <= '0;
    end else if (w_en) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_out_data  <= w_sat;
        r_win_count <= r_win_count + 16'd1;
      end
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign tap_err   = r_tap_err;
  assign win_count = r_win_count;

endmodule

// File: tb/tb_conv_mac.sv
// tb/tb_conv_mac.sv - self-checking bench for conv_mac
module tb_conv_mac;

  logic              Clk = 1'b0;
  logic              reset;
  logic [2:0]        kernel_size;
  logic              in_valid;
  logic [7:0]        in_pixel;
  logic signed [8:0] in_coef;
  logic              in_pad;
  logic              in_last;
  logic              out_ready;

  logic              in_ready,  in_ready1;
  logic              out_valid, out_valid1;
  logic [7:0]        out_data,  out_data1;
  logic              tap_err,   tap_err1;
  logic [15:0]       win_count, win_count1;

  always #5 Clk = ~Clk;

  conv_mac #(.DATA_W(8), .COEF_W(9), .ACC_W(32), .SHIFT(4)) dut (
    .Clk(Clk), .reset(reset), .kernel_size(kernel_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_coef(in_coef), .in_pad(in_pad), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tap_err(tap_err), .win_count(win_count)
  );

  conv_mac #(.DATA_W(8), .COEF_W(9), .ACC_W(32), .SHIFT(0)) dut_s0 (
    .Clk(Clk), .reset(reset), .kernel_size(kernel_size),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pixel(in_pixel),
    .in_coef(in_coef), .in_pad(in_pad), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .tap_err(tap_err1), .win_count(win_count1)
  );

  typedef struct {
    logic [2:0]        ks;
    int                ntaps;
    int                last_idx;
    logic [7:0]        px;
    logic signed [8:0] cf;
    logic [63:0]       pad;
    int                e4;
    int                e0;
    bit                err;
  } vec_t;

  typedef struct {
    int e4;
    int e0;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vt[12];
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model(input longint s, input int sh);
    longint half;
    longint r;
    half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
    r = (s + half) >>> sh;
    if (r < 0) return 0;
    if (r > 255) return 255;
    return int'(r);
  endfunction

  // Scoreboard consumer and hold-stability checker.
  always @(negedge Clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("out_data_s4", out_data, mon_e.e4);
        check("out_data_s0", out_data1, mon_e.e0);
        check("s0_out_valid", out_valid1, 1);
      end
    end
    if (!reset && out_valid && !out_ready) begin
      if (prev_stall) check("hold_data", out_data, prev_data);
      prev_stall = 1'b1;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_pad = 1'b0; out_ready = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  task automatic tap(input logic [7:0] px, input logic signed [8:0] cf,
                     input bit pad, input bit last);
    int g;
    g = 0;
    in_valid = 1'b1; in_pixel = px; in_coef = cf; in_pad = pad; in_last = last;
    @(negedge Clk);
    while (!in_ready && g < 50) begin
      @(negedge Clk);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_pad = 1'b0;
  endtask

  task automatic latency_check();
    @(negedge Clk);
    check("latency_early", out_valid, 0);
    @(negedge Clk);
    check("latency_valid", out_valid, 1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 40) begin
      @(negedge Clk);
      g++;
    end
    check("drain", sb.size(), 0);
    @(posedge Clk);
    #1;
  endtask

  task automatic send_win(input vec_t v);
    kernel_size = v.ks;
    sb.push_back('{v.e4, v.e0});
    for (int i = 0; i < v.ntaps; i++) begin
      tap(v.px, v.cf, v.pad[i], (i == v.last_idx));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    kernel_size = 3'd3; in_pixel = '0; in_coef = '0;
    // ks, ntaps, last_idx, px, cf, pad, exp SHIFT=4, exp SHIFT=0, tap_err
    vt[0]  = '{3'd3,  9,  8, 8'd16,  9'sd1,   64'h0,  9, 144, 1'b0};
    vt[1]  = '{3'd3,  9,  8, 8'd255, 9'sd255, 64'h0, 255, 255, 1'b0};
    vt[2]  = '{3'd3,  9,  8, 8'd255, -9'sd8,  64'h0,  0,   0, 1'b0};
    vt[3]  = '{3'd3,  9,  8, 8'd100, 9'sd2,   64'h7, 75, 255, 1'b0};
    vt[4]  = '{3'd4, 25, 24, 8'd3,   9'sd2,   64'h0,  9, 150, 1'b0};
    vt[5]  = '{3'd0,  1,  0, 8'd1,   9'sd8,   64'h0,  1,   8, 1'b0};
    vt[6]  = '{3'd1,  1,  0, 8'd1,   9'sd7,   64'h0,  0,   7, 1'b0};
    vt[7]  = '{3'd1,  1,  0, 8'd1,   -9'sd8,  64'h0,  0,   0, 1'b0};
    vt[8]  = '{3'd1,  1,  0, 8'd1,   -9'sd9,  64'h0,  0,   0, 1'b0};
    vt[9]  = '{3'd3,  5,  4, 8'd10,  9'sd3,   64'h0,  9, 150, 1'b1};
    vt[10] = '{3'd3,  9, -1, 8'd7,   9'sd3,   64'h0, 12, 189, 1'b1};
    vt[11] = '{3'd6, 49, 48, 8'd1,   9'sd1,   64'h0,  3,  49, 1'b0};

    do_reset();
    @(negedge Clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_tap_err", tap_err, 0);
    check("rst_win_count", win_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge Clk); #1;

    for (int n = 0; n < 12; n++) begin
      do_reset();
      send_win(vt[n]);
      latency_check();
      wait_drain();
      check("vec_win_count", win_count, 1);
      check("vec_tap_err", tap_err, vt[n].err);
      check("vec_s0_tap_err", tap_err1, vt[n].err);
    end

    // K=1 back-to-back stream with a 3-cycle downstream stall.
    do_reset();
    kernel_size = 3'd1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [7:0] px;
          px = 8'(10 + i * 17);
          sb.push_back('{model(16 * longint'(px), 4), model(16 * longint'(px), 0)});
          tap(px, 9'sd16, 1'b0, 1'b1);
        end
      end
      begin
        repeat (6) @(posedge Clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge Clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_s0_in_ready", in_ready1, in_ready);
        end
        @(posedge Clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stream_win_count", win_count, 12);
    check("stream_s0_win_count", win_count1, 12);
    check("stream_tap_err", tap_err, 0);

    // Early close on tap 5, then a 9-tap window with no in_last.
    do_reset();
    kernel_size = 3'd3;
    sb.push_back('{9, 150});
    for (int i = 0; i < 5; i++) tap(8'd10, 9'sd3, 1'b0, (i == 4));
    sb.push_back('{12, 189});
    for (int i = 0; i < 9; i++) tap(8'd7, 9'sd3, 1'b0, 1'b0);
    wait_drain();
    check("close_win_count", win_count, 2);
    check("close_tap_err", tap_err, 1);

    // Reset in the middle of a K=5 window, then a clean window.
    kernel_size = 3'd5;
    for (int i = 0; i < 4; i++) tap(8'd50, 9'sd50, 1'b0, 1'b0);
    do_reset();
    @(negedge Clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_tap_err", tap_err, 0);
    check("midrst_win_count", win_count, 0);
    @(posedge Clk); #1;
    sb.push_back('{9, 150});
    for (int i = 0; i < 25; i++) tap(8'd3, 9'sd2, 1'b0, (i == 24));
    latency_check();
    wait_drain();
    check("postrst_win_count", win_count, 1);
    check("postrst_tap_err", tap_err, 0);

    // Kernel size change mid-window is ignored until the window ends.
    do_reset();
    kernel_size = 3'd3;
    sb.push_back('{9, 144});
    for (int i = 0; i < 9; i++) begin
      if (i == 3) kernel_size = 3'd1;
      tap(8'd4, 9'sd4, 1'b0, (i == 8));
    end
    wait_drain();
    check("kschg_win_count", win_count, 1);
    check("kschg_tap_err", tap_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
